// File: rtl/interp_sequencer.sv
// Wavetable interpolation sequencer: on each accepted sample tick, fetches two
// adjacent table entries and the phase fraction, then latches the interpolated sample.
module interp_sequencer #(
    parameter int IDX_W  = 8,
    parameter int FRAC_W = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    tick,
    input  logic [IDX_W+FRAC_W-1:0] tune,
    output logic [IDX_W-1:0]        rom_addr,
    input  logic [7:0]              rom_data,
    output logic [FRAC_W-1:0]       fraction,
    output logic [7:0]              wave1,
    output logic [7:0]              wave2,
    input  logic [11:0]             interp_out,
    output logic [11:0]             sample,
    output logic                    sample_valid,
    output logic                    busy,
    output logic                    overrun,
    input  logic                    clr_ovr
);

    localparam int PH_W = IDX_W + FRAC_W;

    typedef enum logic [2:0] {
        IDLE,
        A1,
        A2,
        W2,
        SET
    } state_t;

    state_t          state;
    logic [PH_W-1:0] ph;
    logic [PH_W-1:0] tune_q;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ph           <= '0;
            tune_q       <= '0;
            rom_addr     <= '0;
            fraction     <= '0;
            wave1        <= '0;
            wave2        <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            // A tick that arrives mid-conversion is dropped; set beats clear.
            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (tick && en) begin
                        state    <= A1;
                        rom_addr <= ph[PH_W-1:FRAC_W];
                        fraction <= ph[FRAC_W-1:0];
                        tune_q   <= tune;
                    end
                end
                A1: begin
                    state    <= A2;
                    rom_addr <= rom_addr + IDX_W'(1);
                end
                A2: begin
                    state <= W2;
                    wave1 <= rom_data;
                end
                W2: begin
                    state <= SET;
                    wave2 <= rom_data;
                end
                SET: begin
                    state        <= IDLE;
                    sample       <= interp_out;
                    sample_valid <= 1'b1;
                    ph           <= ph + tune_q;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_interp_sequencer.sv
// Directed bench for interp_sequencer: table-driven conversions plus
// hand-written overrun, enable-gating and mid-conversion reset sequences.
module tb_interp_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        tick;
    logic [16:0] tune;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [8:0]  fraction;
    logic [7:0]  wave1;
    logic [7:0]  wave2;
    logic [11:0] interp_out;
    logic [11:0] sample;
    logic        sample_valid;
    logic        busy;
    logic        overrun;
    logic        clr_ovr;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // ROM[k] = 2k, registered read.
    always @(posedge clk) rom_data <= {rom_addr[6:0], 1'b0};

    // Stand-in interpolator that depends on all three operands.
    assign interp_out = {wave2[3:0], wave1} ^ {3'b000, fraction};

    interp_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .tick         (tick),
        .tune         (tune),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .fraction     (fraction),
        .wave1        (wave1),
        .wave2        (wave2),
        .interp_out   (interp_out),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun),
        .clr_ovr      (clr_ovr)
    );

    typedef struct {
        logic [16:0] tune;
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [8:0]  frac;
        logic [7:0]  w1;
        logic [7:0]  w2;
        logic [11:0] smp;
    } vec_t;

    vec_t vec [7];
    vec_t v0;
    vec_t v1;
    string cur;
    int pulses;
    int first;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0h, expected %0h", cur, nm, act, exp);
        end
    endtask

    // Caller is at a negedge; the tick is accepted at the next rising edge.
    task automatic run_conv(input vec_t v);
        tick = 1'b1;
        tune = v.tune;
        @(posedge clk); #1;
        tick = 1'b0;
        tune = 17'($urandom);
        chk("busy_e0", 32'(busy), 1);
        chk("addr_e0", 32'(rom_addr), 32'(v.a0));
        chk("frac_e0", 32'(fraction), 32'(v.frac));
        chk("sv_e0", 32'(sample_valid), 0);
        @(posedge clk); #1;
        chk("addr_e1", 32'(rom_addr), 32'(v.a1));
        @(posedge clk); #1;
        chk("wave1_e2", 32'(wave1), 32'(v.w1));
        @(posedge clk); #1;
        chk("wave2_e3", 32'(wave2), 32'(v.w2));
        chk("sv_e3", 32'(sample_valid), 0);
        @(posedge clk); #1;
        chk("sv_e4", 32'(sample_valid), 1);
        chk("sample_e4", 32'(sample), 32'(v.smp));
        chk("busy_e4", 32'(busy), 0);
        @(posedge clk); #1;
        chk("sv_e5", 32'(sample_valid), 0);
        chk("frac_hold", 32'(fraction), 32'(v.frac));
        chk("w1_hold", 32'(wave1), 32'(v.w1));
        chk("w2_hold", 32'(wave2), 32'(v.w2));
    endtask

    // Ten-edge window starting with an accepted tick at edge 0; optional
    // busy tick (with optional clear) and en drop at given edge numbers.
    task automatic run_raw(input int busy_at, input bit clr_with,
                           input int en_off_at, output int np,
                           output int fp);
        np = 0;
        fp = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            tune    = 17'h0;
            tick    = (c == 0) || (c == busy_at);
            clr_ovr = (c == busy_at) && clr_with;
            if (en_off_at >= 0 && c >= en_off_at) en = 1'b0;
            @(posedge clk); #1;
            if (sample_valid) begin
                np++;
                if (fp < 0) fp = c;
            end
        end
        tick    = 1'b0;
        clr_ovr = 1'b0;
        en      = 1'b1;
    endtask

    initial begin
        vec[0] = '{17'h00200, 8'd0,   8'd1, 9'h000, 8'h00, 8'h02, 12'h200};
        vec[1] = '{17'h00000, 8'd1,   8'd2, 9'h000, 8'h02, 8'h04, 12'h402};
        vec[2] = '{17'h1FF00, 8'd1,   8'd2, 9'h000, 8'h02, 8'h04, 12'h402};
        vec[3] = '{17'h00080, 8'd0,   8'd1, 9'h100, 8'h00, 8'h02, 12'h300};
        vec[4] = '{17'h1FC80, 8'd0,   8'd1, 9'h180, 8'h00, 8'h02, 12'h380};
        vec[5] = '{17'h00400, 8'd255, 8'd0, 9'h000, 8'hFE, 8'h00, 12'h0FE};
        vec[6] = '{17'h00000, 8'd1,   8'd2, 9'h000, 8'h02, 8'h04, 12'h402};
        v0 = vec[0];
        v1 = vec[1];

        rst_n   = 1'b0;
        en      = 1'b1;
        tick    = 1'b0;
        tune    = 17'h0;
        clr_ovr = 1'b0;
        cur     = "reset";
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("addr", 32'(rom_addr), 0);
        chk("busy", 32'(busy), 0);
        chk("sv", 32'(sample_valid), 0);
        chk("sample", 32'(sample), 0);
        chk("ovr", 32'(overrun), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            cur = $sformatf("vec%0d", i);
            @(negedge clk);
            run_conv(vec[i]);
        end

        cur = "ovr_e2";
        run_raw(2, 1'b0, -1, pulses, first);
        chk("pulses", 32'(pulses), 1);
        chk("first", 32'(first), 4);
        chk("ovr", 32'(overrun), 1);
        cur = "ovr_ph";
        @(negedge clk);
        run_conv(v1);

        cur = "ovr_clr";
        run_raw(2, 1'b1, -1, pulses, first);
        chk("pulses", 32'(pulses), 1);
        chk("ovr", 32'(overrun), 1);
        @(negedge clk);
        clr_ovr = 1'b1;
        @(posedge clk); #1;
        clr_ovr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 0);

        cur = "ovr_set";
        run_raw(4, 1'b0, -1, pulses, first);
        chk("pulses", 32'(pulses), 1);
        chk("first", 32'(first), 4);
        chk("ovr", 32'(overrun), 1);
        @(negedge clk);
        clr_ovr = 1'b1;
        @(posedge clk); #1;
        clr_ovr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 0);

        cur = "en_gate";
        @(negedge clk);
        en   = 1'b0;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        en   = 1'b1;
        chk("busy", 32'(busy), 0);
        chk("ovr", 32'(overrun), 0);

        cur = "en_drop";
        run_raw(-1, 1'b0, 2, pulses, first);
        chk("pulses", 32'(pulses), 1);
        chk("first", 32'(first), 4);

        cur = "rst_mid";
        @(negedge clk);
        tick = 1'b1;
        tune = 17'h0;
        @(posedge clk); #1;
        tick = 1'b0;
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        chk("ovr_pre", 32'(overrun), 1);
        @(posedge clk); #1;
        chk("busy_w2", 32'(busy), 1);
        chk("wave1_w2", 32'(wave1), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("addr", 32'(rom_addr), 0);
        chk("frac", 32'(fraction), 0);
        chk("wave1", 32'(wave1), 0);
        chk("wave2", 32'(wave2), 0);
        chk("sample", 32'(sample), 0);
        chk("busy", 32'(busy), 0);
        chk("ovr", 32'(overrun), 0);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (sample_valid) pulses++;
        end
        chk("no_sv", 32'(pulses), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cur = "post_rst";
        run_conv(v0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/interp_sequencer.md
INTERP_SEQUENCER -- requirements
Module: interp_sequencer

Interface
REQ-001 SHALL have parameter IDX_W, default 8: wavetable index width (table depth 2^IDX_W).
REQ-002 SHALL have parameter FRAC_W, default 9: fraction width; phase width PH_W = IDX_W+FRAC_W (17).
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1: start enable; gates acceptance of tick only.
REQ-006 SHALL have port tick, input, 1: sample-rate strobe, one clk wide.
REQ-007 SHALL have port tune, input, PH_W: phase increment per accepted tick.
REQ-008 SHALL have port rom_addr, output, IDX_W: registered wavetable address.
REQ-009 SHALL have port rom_data, input, 8: synchronous ROM data, valid one edge after the ROM samples rom_addr.
REQ-010 SHALL have ports fraction (output, FRAC_W), wave1 (output, 8) and wave2 (output, 8): registered operands to the interpolator.
REQ-011 SHALL have port interp_out, input, 12: combinational interpolator result.
REQ-012 SHALL have ports sample (output, 12), sample_valid (output, 1, one-cycle pulse) and busy (output, 1).
REQ-013 SHALL have ports overrun (output, 1, sticky) and clr_ovr (input, 1).

Function
REQ-014 SHALL keep phase register ph[PH_W-1:0]; idx = ph[PH_W-1:FRAC_W], frac = ph[FRAC_W-1:0].
REQ-015 SHALL implement FSM states IDLE, A1, A2, W2, SET; busy = (state != IDLE).
REQ-016 SHALL, at edge E0 with state IDLE, tick=1 and en=1: go to A1, set rom_addr<=idx, fraction<=frac, and latch tune into tune_q.
REQ-017 SHALL, at E1 (A1): go to A2 and set rom_addr<=idx+1 modulo 2^IDX_W (255 wraps to 0).
REQ-018 SHALL, at E2 (A2): go to W2 and capture wave1<=rom_data (=ROM[idx]).
REQ-019 SHALL, at E3 (W2): go to SET and capture wave2<=rom_data (=ROM[idx+1]).
REQ-020 SHALL, at E4 (SET): set sample<=interp_out, pulse sample_valid high for exactly the following cycle, set ph<=ph+tune_q modulo 2^PH_W, and return to IDLE.
REQ-021 SHALL give a fixed latency of 4 clk edges from accepting tick to sample_valid assertion, and SHALL never let sample_valid stay high for 2 consecutive cycles.
REQ-022 SHALL hold fraction, wave1 and wave2 stable from their capture until the next accepted tick.
REQ-023 SHALL, when tick=1 while state != IDLE (including SET at E4): drop the tick, leave ph and the FSM unaffected, and set overrun<=1.
REQ-024 SHALL, when tick=1 with en=0 in IDLE: take no action and leave overrun unchanged.
REQ-025 SHALL, when en is deasserted mid-conversion, complete that conversion normally.
REQ-026 SHALL clear overrun on clr_ovr=1; when set and clear coincide, set SHALL win.
REQ-027 SHALL ignore tune changes during A1..SET, using tune_q only.
REQ-028 SHALL, for tune=0, repeat the same idx/frac on every tick.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force: state=IDLE, ph=0, tune_q=0, rom_addr=0, fraction=0, wave1=0, wave2=0, sample=0, sample_valid=0, busy=0, overrun=0.
REQ-030 SHALL abort any conversion in progress on reset (no sample_valid), and SHALL accept a tick at the first edge after rst_n rises.

Verification
REQ-031 SHALL cover basic conversion: ROM[k]=2k, tune=0x00200, en=1, one tick -> rom_addr 0 then 1, wave1=0, wave2=2, fraction=0, sample_valid 4 edges after tick, ph=0x00200.
REQ-032 SHALL cover fraction: ph=0x00100, tune=0x00080 -> fraction=0x100, and after the conversion ph=0x00180.
REQ-033 SHALL cover wrap: ph=0x1FE00, tune=0x00400 -> rom_addr 255 then 0, and after the conversion ph=0x00200.
REQ-034 SHALL cover overrun: tick at E0 and again at E2 -> one sample_valid, overrun=1; clr_ovr coincident with a third busy tick -> overrun stays 1.
REQ-035 SHALL cover reset mid-operation: rst_n low during W2 -> all outputs 0 immediately, no sample_valid; tick after release -> normal conversion from ph=0.
REQ-036 SHALL cover en gating: en=0 with tick -> busy stays 0; en dropped in A2 -> conversion still completes.
